ysyx_23060203_mem_arbiter: RTL
==============================

Name: ysyx_23060203_mem_arbiter

Overview:
Shares the single data-memory port between the instruction fetcher (master 0, read-only) and the load/store path (master 1, read/write).
Round-robin arbitration; one outstanding transaction at a time.
For master 1 it translates the 3-bit RV load/store funct into a word-aligned address, byte write mask and shifted write data, and sign/zero-extends load data.
Sits between IFU/EXU and the memory model/bus bridge.

Parameters:
ADDR_W, 32, address width of all ports
FIRST_PRIO, 1, master granted first after reset when both request (0=IFU, 1=LSU)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
m0_req_valid  in  1  IFU fetch request
m0_req_ready  out  1  IFU request accepted this cycle
m0_addr  in  ADDR_W  fetch address (word aligned)
m0_resp_valid  out  1  one-cycle pulse, fetch data valid
m0_resp_data  out  32  fetched word
m1_req_valid  in  1  LSU request
m1_req_ready  out  1  LSU request accepted this cycle
m1_wen  in  1  1=store, 0=load
m1_func  in  3  funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
m1_addr  in  ADDR_W  byte address
m1_wdata  in  32  store data, LSB-aligned
m1_resp_valid  out  1  one-cycle pulse, load data valid / store done
m1_resp_data  out  32  extended load data (0 for stores)
s_req_valid  out  1  memory request
s_req_ready  in  1  memory accepts request
s_wen  out  1  write enable
s_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
s_wdata  out  32  lane-shifted write data
s_wmask  out  4  byte write mask (0 for reads)
s_resp_valid  in  1  memory response
s_resp_data  in  32  read word

Behaviour:
- Reset: state IDLE, all outputs 0, last-grant = !FIRST_PRIO; any in-flight transaction is dropped; no response is ever delivered for it.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If only one master is valid, it is granted. If both are valid, the one not granted last wins.
  - The granted mx_req_ready is 1 for that cycle (combinational from valid and state). The request fields are latched, the owner is recorded, and the FSM goes to REQ.
  - The non-granted master's ready stays 0.
- REQ: s_req_valid=1 with registered s_* fields, held stable until s_req_ready=1, then go to WAIT.
- WAIT: wait for s_resp_valid. s_resp_valid seen in any other state is ignored. On s_resp_valid, register the extended data and go to RESP.
- RESP: the owner's mx_resp_valid=1 for exactly one cycle with data, then go to IDLE.
- Latency: request acceptance at cycle t → s_req_valid at t+1. Master response is 1 cycle after s_resp_valid. Minimum accept-to-response is 3 cycles with zero-wait memory.
- Requests cannot be accepted in REQ, WAIT or RESP (readies are 0). The next grant occurs in the IDLE cycle following RESP.
- Lane rules for master 1, with off = addr[1:0]:
  - b: wmask = 1<<off; wdata = wdata[7:0] replicated to all lanes.
  - h: wmask = 3<<{off[1],1'b0}; wdata = wdata[15:0] replicated to both halves.
  - w: wmask = 4'hF.
  - Misalignment is not trapped: h uses off[1] only; w ignores off.
- Loads:
  - Select byte rdata[8*off +: 8] or half rdata[16*off[1] +: 16].
  - 000 and 001 sign-extend; 100 and 101 zero-extend; 010 passes the word through.
  - Undefined funct values are treated as 010.
- Master 0 is always a word read: wmask=0, wen=0, s_addr = m0_addr with the low 2 bits cleared.
- Response data of the non-owning master: held at its previous value; its valid stays 0.

Decomposition:
- Shared params include (alongside the opcode params): the funct3 constants (F_B, F_H, F_W, F_BU, F_HU) and the FSM state encodings.
- One natural sub-module: ysyx_23060203_mem_lane, purely combinational. It implements funct+offset → wmask/wdata for stores and rdata → extended data for loads.
- The arbiter FSM stays in the top module.

Test Plan:
- Reset, then m0 alone requests addr 0x8000_0004; memory returns 0x1234_5678 with zero wait → s_addr=0x8000_0004, s_wmask=0, m0_resp_valid pulse 3 cycles after accept, data 0x1234_5678.
- Both masters valid every cycle, FIRST_PRIO=1 → grant order LSU, IFU, LSU, IFU. Each master's ready is seen exactly once per round, never together.
- m1 store sb, addr 0x8000_0003, wdata 0xAB → s_addr=0x8000_0000, s_wmask=4'b1000, s_wdata[31:24]=0xAB, m1_resp_data=0.
- m1 loads with mem word 0x80FF_7F01: lb @+3 → 0xFFFF_FF80; lbu @+3 → 0x0000_0080; lh @+2 → 0xFFFF_80FF; lhu @+0 → 0x0000_7F01; lw → 0x80FF_7F01.
- s_req_ready held low 5 cycles → s_req_valid and all s_* fields stable throughout. A spurious s_resp_valid during REQ is ignored and produces no master response.
- rstn asserted low during WAIT → outputs 0 immediately (asynchronous). After release, the late s_resp_valid produces no mx_resp_valid, and a new m0 request is served normally.

Source files
------------

// File: rtl/ysyx_23060203_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_mem_arbiter_pkg
// Purpose  : Shared constants for the data-memory arbiter: RV load/store
//            funct3 codes and the arbiter state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060203_mem_arbiter_pkg;

    // RV32 load/store funct3 codes
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    // Arbiter states
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060203_mem_lane.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_mem_lane
// Purpose  : Purely combinational byte-lane steering for the load/store path.
//            Stores: funct3 + address offset -> byte mask and lane-replicated
//            write data. Loads: read word -> selected, extended result.
// Ports    : i_func  funct3 of the access
//            i_off   byte offset (address bits [1:0])
//            i_wdata LSB-aligned store data
//            i_rdata raw word returned by memory
//            o_wmask byte write mask for a store
//            o_wdata lane-replicated store data
//            o_rdata sign/zero-extended load result
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_mem_lane
    import ysyx_23060203_mem_arbiter_pkg::*;
(
    input  logic [2:0]  i_func,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword accesses only look at off[1]; misalignment is not trapped.
    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

    // Store steering: data is replicated across lanes so the mask alone
    // decides which bytes memory actually writes.
    always_comb begin
        o_wmask = 4'hF;
        o_wdata = i_wdata;
        case (i_func)
            F_B, F_BU: begin
                o_wmask = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F_H, F_HU: begin
                o_wmask = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wmask = 4'hF;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load extension; any undefined funct3 behaves as a full word load.
    always_comb begin
        o_rdata = i_rdata;
        case (i_func)
            F_B:     o_rdata = {{24{w_byte[7]}}, w_byte};
            F_BU:    o_rdata = {24'd0, w_byte};
            F_H:     o_rdata = {{16{w_half[15]}}, w_half};
            F_HU:    o_rdata = {16'd0, w_half};
            F_W:     o_rdata = i_rdata;
            default: o_rdata = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060203_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_mem_arbiter
// Purpose  : Shares one data-memory port between the instruction fetcher
//            (master 0, word reads only) and the load/store unit (master 1).
//            Round-robin grant, one outstanding transaction at a time.
// Ports    : clk, rstn          clock, asynchronous active-low reset
//            m0_*               IFU request / response
//            m1_*               LSU request (funct3-encoded) / response
//            s_*                memory-side request / response
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit FIRST_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_resp_valid,
    output logic [31:0]       m0_resp_data,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_wen,
    input  logic [2:0]        m1_func,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_resp_valid,
    output logic [31:0]       m1_resp_data,
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic              s_wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wmask,
    input  logic              s_resp_valid,
    input  logic [31:0]       s_resp_data
);

    localparam logic [ADDR_W-1:0] C_WORD_MASK = ~(ADDR_W'(3));

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_next_state;
    logic              r_owner;       // 1 = LSU owns the current transaction
    logic              r_last_grant;  // 1 = LSU was granted most recently
    logic [2:0]        r_func;
    logic [1:0]        r_off;
    logic              r_s_wen;
    logic [ADDR_W-1:0] r_s_addr;
    logic [31:0]       r_s_wdata;
    logic [3:0]        r_s_wmask;
    logic [31:0]       r_m0_resp_data;
    logic [31:0]       r_m1_resp_data;

    logic              w_idle;
    logic              w_pick1;
    logic              w_accept;
    logic [2:0]        w_lane_func;
    logic [1:0]        w_lane_off;
    logic [3:0]        w_lane_wmask;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_lane_rdata;

    assign w_idle   = (r_state == ST_IDLE);
    // LSU wins when alone, or when both ask and the IFU was served last.
    assign w_pick1  = m1_req_valid & (~m0_req_valid | ~r_last_grant);
    assign w_accept = w_idle & (m0_req_valid | m1_req_valid);

    // One lane unit serves both directions: in IDLE it steers the incoming
    // store, afterwards it extends the returning load with the latched funct.
    assign w_lane_func = w_idle ? m1_func      : r_func;
    assign w_lane_off  = w_idle ? m1_addr[1:0] : r_off;

    ysyx_23060203_mem_lane u_lane (
        .i_func  (w_lane_func),
        .i_off   (w_lane_off),
        .i_wdata (m1_wdata),
        .i_rdata (s_resp_data),
        .o_wmask (w_lane_wmask),
        .o_wdata (w_lane_wdata),
        .o_rdata (w_lane_rdata)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)     w_next_state = ST_REQ;
            ST_REQ:  if (s_req_ready)  w_next_state = ST_WAIT;
            ST_WAIT: if (s_resp_valid) w_next_state = ST_RESP;
            ST_RESP:                   w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Readies are gated by rstn so every output reads 0 while reset is held.
    always_comb begin
        m0_req_ready  = rstn & w_idle & m0_req_valid & ~w_pick1;
        m1_req_ready  = rstn & w_idle & w_pick1;
        s_req_valid   = (r_state == ST_REQ);
        m0_resp_valid = (r_state == ST_RESP) & ~r_owner;
        m1_resp_valid = (r_state == ST_RESP) & r_owner;
    end

    // ---------------- Request latch ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner      <= 1'b0;
            r_last_grant <= ~FIRST_PRIO;
            r_func       <= 3'd0;
            r_off        <= 2'd0;
            r_s_wen      <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= 32'd0;
            r_s_wmask    <= 4'd0;
        end else if (w_accept) begin
            r_owner      <= w_pick1;
            r_last_grant <= w_pick1;
            if (w_pick1) begin
                r_func    <= m1_func;
                r_off     <= m1_addr[1:0];
                r_s_wen   <= m1_wen;
                r_s_addr  <= m1_addr & C_WORD_MASK;
                r_s_wdata <= w_lane_wdata;
                r_s_wmask <= m1_wen ? w_lane_wmask : 4'd0;
            end else begin
                r_func    <= F_W;
                r_off     <= 2'd0;
                r_s_wen   <= 1'b0;
                r_s_addr  <= m0_addr & C_WORD_MASK;
                r_s_wdata <= 32'd0;
                r_s_wmask <= 4'd0;
            end
        end
    end

    // ---------------- Response capture ----------------
    // Only the owner's data register moves; the other master's holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m0_resp_data <= 32'd0;
            r_m1_resp_data <= 32'd0;
        end else if ((r_state == ST_WAIT) && s_resp_valid) begin
            if (r_owner) begin
                r_m1_resp_data <= r_s_wen ? 32'd0 : w_lane_rdata;
            end else begin
                r_m0_resp_data <= s_resp_data;
            end
        end
    end

    assign s_wen        = r_s_wen;
    assign s_addr       = r_s_addr;
    assign s_wdata      = r_s_wdata;
    assign s_wmask      = r_s_wmask;
    assign m0_resp_data = r_m0_resp_data;
    assign m1_resp_data = r_m1_resp_data;

endmodule
`default_nettype wire
